im_fetch_ctrl: RTL and testbench
================================

# im_fetch_ctrl

Instruction-fetch controller that sequences the byte-addressed instruction memory (8-bit address, 32-bit combinational read data) and feeds fetched words to the decode stage. It owns the program counter and a small prefetch FIFO with a valid/ready handshake to decode. It also handles start/halt control and branch/jump redirects with flush. It sits between the pipeline control logic and the instruction memory, at the front of the pipeline.

## Interface
- RESET_PC, 8'd0, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries (2..4).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin or resume fetching (IDLE/HALT -> RUN).
- halt  in  1  stop fetching (RUN -> HALT); FIFO keeps draining.
- redirect_valid  in  1  branch/jump taken; flush and reload PC.
- redirect_addr  in  8  redirect target, byte address.
- im_addr  out  8  instruction memory address; always equals pc.
- im_instr  in  32  instruction memory read data, combinational from im_addr.
- dec_valid  out  1  FIFO head holds a valid instruction.
- dec_ready  in  1  decode accepts the head this cycle.
- dec_instr  out  32  FIFO head instruction.
- dec_pc  out  8  address the head was fetched from.
- pc  out  8  current fetch PC.
- busy  out  1  high in RUN.
- fetch_count  out  16  instructions pushed since reset; wraps at 16'hFFFF -> 0.

## Operation
- States: IDLE (reset state), RUN, HALT. IDLE -start-> RUN. RUN -halt-> HALT. HALT -start-> RUN, resuming at the current pc. If halt and start are both high in the same cycle, halt wins.
- Push condition: state==RUN && !redirect_valid && (count<DEPTH || pop). pop = dec_valid && dec_ready.
- On push, the FIFO tail captures {im_instr, pc}, then pc <= pc+4 and fetch_count increments.
- PC arithmetic is 8-bit modulo: 8'd252 + 4 = 8'd0. The PC is always word-aligned.
- Redirect is valid in any state and has the highest priority. It clears all FIFO entries, including any same-cycle pop or push, and loads pc <= {redirect_addr[7:2],2'b00}. State is unchanged and fetch_count does not increment.
- In IDLE and HALT no pushes occur. Pops continue, so the FIFO drains normally.
- Push and pop are allowed in the same cycle when the FIFO is full. Count is unchanged in that case.
- dec_instr and dec_pc are driven from the FIFO head. They hold stable while dec_valid && !dec_ready.
- When the FIFO is empty, dec_valid=0 and dec_instr/dec_pc are don't-care; the bench checks them only when dec_valid=1.

## Timing
- Reset (async assert, deassertion synchronous to clk): state=IDLE, pc=im_addr=RESET_PC, FIFO empty, dec_valid=0, dec_instr=0, dec_pc=0, busy=0, fetch_count=0.
- Fetch latency: an instruction at pc in cycle N, if pushed, shows dec_valid=1 with dec_pc=N's pc in cycle N+1.
- Throughput: one instruction per cycle while dec_ready=1.
- Start: start high in cycle N gives busy=1 and the first push in cycle N+1.
- Halt: halt high in cycle N means the cycle-N push still occurs. busy=0 and no push from N+1.
- Redirect in cycle N: dec_valid=0 in N+1. The target instruction is pushed in N+1 if RUN and appears on dec in N+2.
- Backpressure: with dec_ready=0, the FIFO fills after DEPTH pushes and pc freezes.
- Reset mid-operation: all state returns to reset values immediately, FIFO contents are discarded, and the block stays in IDLE until start.

## Test plan
- Program preload (0:0x00000000, 4:0x14210003, 8:0x1442000A, 12:0x20000007), start pulse, dec_ready=1 -> dec_pc 0,4,8,12 with those words on consecutive cycles; fetch_count=4 after 4 pushes.
- dec_ready=0 after start -> two pushes (pc 0,4), pc frozen at 8, dec_instr held at 0x00000000. Then dec_ready=1 -> dec_pc 0,4,8 in consecutive cycles with no gap or duplicate.
- Redirect to 8'd46 while the FIFO holds pc 16,20 -> the next valid output has dec_pc=44, dec_instr=0x1C220000, and no entry for pc 16 or 20 is ever accepted.
- Redirect to 8'd252 in RUN -> dec_pc 252 then 0 (wrap). Redirect with a simultaneous pop and push -> FIFO empty next cycle and fetch_count unchanged.
- Halt and start high in the same cycle in RUN -> HALT (busy=0) and the FIFO drains. A later start alone resumes at the held pc without reset.
- rst_n asserted mid-run with a full FIFO -> dec_valid=0, pc=0, fetch_count=0, and busy=0 without waiting for a clock edge.

Source files
------------

// File: rtl/im_fetch_ctrl_if.sv
// ============================================================================
// im_fetch_ctrl_if : instruction-memory bus and decode handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface im_fetch_ctrl_if;
  logic [7:0]  im_addr;
  logic [31:0] im_instr;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [7:0]  dec_pc;

  // Fetch controller side
  modport master (
    output im_addr,
    input  im_instr,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc
  );

  // Memory / decode side
  modport slave (
    input  im_addr,
    output im_instr,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc
  );
endinterface

`default_nettype wire

// File: rtl/im_fetch_ctrl.sv
// ============================================================================
// im_fetch_ctrl : PC sequencing, prefetch FIFO and redirect/flush control
// Rev 1.0
// ============================================================================
`default_nettype none

module im_fetch_ctrl #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter int         DEPTH    = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic        halt,
  input  wire logic        redirect_valid,
  input  wire logic [7:0]  redirect_addr,
  im_fetch_ctrl_if.master  bus,
  output logic [7:0]       pc,
  output logic             busy,
  output logic [15:0]      fetch_count
);

  // Storage is sized for the largest legal depth so the 2-bit pointers
  // index it exactly; only the first DEPTH entries are ever written.
  localparam int MAX_DEPTH = 4;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = 3;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         pc_q, pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        fetch_count_q, fetch_count_d;
  logic [31:0]        instr_q [MAX_DEPTH];
  logic [31:0]        instr_d [MAX_DEPTH];
  logic [7:0]         epc_q   [MAX_DEPTH];
  logic [7:0]         epc_d   [MAX_DEPTH];

  logic               pop;
  logic               push;

  always_comb begin
    pop  = (count_q != '0) && bus.dec_ready;
    push = (state_q == ST_RUN) && !redirect_valid && ((count_q < DEPTH_C) || pop);
  end

  // Halt takes precedence over start whenever both are asserted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !halt) state_d = ST_RUN;
      ST_RUN:  if (halt)           state_d = ST_HALT;
      ST_HALT: if (start && !halt) state_d = ST_RUN;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      // Flush overrides any pop/push requested in the same cycle.
      pc_d     = {redirect_addr[7:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d          = pc_q + 8'd4;
        wr_ptr_d      = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        fetch_count_d = fetch_count_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_DEPTH; i++) begin
      instr_d[i] = instr_q[i];
      epc_d[i]   = epc_q[i];
      if (push && (wr_ptr_q == PTR_W'(i))) begin
        instr_d[i] = bus.im_instr;
        epc_d[i]   = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fetch_count_q <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        instr_q[i] <= instr_d[i];
        epc_q[i]   <= epc_d[i];
      end
    end
  end

  always_comb begin
    bus.im_addr   = pc_q;
    bus.dec_valid = (count_q != '0);
    bus.dec_instr = instr_q[rd_ptr_q];
    bus.dec_pc    = epc_q[rd_ptr_q];
    pc            = pc_q;
    busy          = (state_q == ST_RUN);
    fetch_count   = fetch_count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_im_fetch_ctrl.sv
// ============================================================================
// tb_im_fetch_ctrl : cycle table plus in-order accepted-instruction scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_im_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_addr = 8'd0;
  logic [7:0]  pc;
  logic        busy;
  logic [15:0] fetch_count;

  logic [31:0] imem [64];

  im_fetch_ctrl_if bus ();

  assign bus.im_instr = imem[bus.im_addr[7:2]];

  im_fetch_ctrl #(
    .RESET_PC (8'd0),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus),
    .pc             (pc),
    .busy           (busy),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t exp_q [$];

  typedef struct {
    logic        st;
    logic        hl;
    logic        rv;
    logic [7:0]  ra;
    logic        rdy;
    logic        dv;
    logic [7:0]  dpc;
    logic [7:0]  pcv;
    logic        bsy;
    logic [15:0] fc;
  } vec_t;

  vec_t vt [23];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic st, input logic hl, input logic rv,
                              input logic [7:0] ra, input logic rdy, input logic dv,
                              input logic [7:0] dpc, input logic [7:0] pcv,
                              input logic bsy, input logic [15:0] fc);
    vec_t r;
    r.st = st; r.hl = hl; r.rv = rv; r.ra = ra; r.rdy = rdy;
    r.dv = dv; r.dpc = dpc; r.pcv = pcv; r.bsy = bsy; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = imem[a[7:2]];
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs at the falling edge, then score any handshake
  // that will complete at the next rising edge (flushed pops are not accepts).
  task automatic cyc(input logic st, input logic hl, input logic rv,
                     input logic [7:0] ra, input logic rdy);
    exp_t e;
    @(negedge clk);
    start = st; halt = hl; redirect_valid = rv; redirect_addr = ra;
    bus.dec_ready = rdy;
    #1;
    if (rst_n && !redirect_valid && bus.dec_valid && bus.dec_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_accept_pc", {24'd0, bus.dec_pc}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", {24'd0, bus.dec_pc}, {24'd0, e.pc});
        chk("sb_instr", bus.dec_instr, e.instr);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; bus.dec_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hC0DE_0000 | (i << 2);
    imem[0]  = 32'h0000_0000;
    imem[1]  = 32'h1421_0003;
    imem[2]  = 32'h1442_000A;
    imem[3]  = 32'h2000_0007;
    imem[11] = 32'h1C22_0000;
    bus.dec_ready = 1'b0;

    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    #3;
    chk("rst_dec_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("rst_dec_instr", bus.dec_instr, 32'd0);
    chk("rst_dec_pc", {24'd0, bus.dec_pc}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_im_addr", {24'd0, bus.im_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---------------- backpressure from start ----------------
    cyc(1, 0, 0, 8'd0, 0);
    cyc(0, 0, 0, 8'd0, 0);
    cyc(0, 0, 0, 8'd0, 0);
    cyc(0, 0, 0, 8'd0, 0);
    chk("bp_pc_frozen", {24'd0, pc}, 32'd8);
    chk("bp_dec_valid", {31'd0, bus.dec_valid}, 32'd1);
    chk("bp_dec_instr_held", bus.dec_instr, 32'h0000_0000);
    chk("bp_fetch_count", {16'd0, fetch_count}, 32'd2);
    cyc(0, 0, 0, 8'd0, 0);
    chk("bp_pc_still_frozen", {24'd0, pc}, 32'd8);
    push_exp(8'd0); push_exp(8'd4); push_exp(8'd8);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 8'd0, 1);
      chk("bp_drain_no_gap", {31'd0, bus.dec_valid}, 32'd1);
    end
    cyc(0, 0, 0, 8'd0, 0);
    chk("bp_sb_drained", exp_q.size(), 32'd0);

    // ---------------- main cycle table ----------------
    do_reset();
    vt[0]  = mk(1,0,0,8'd0,  1, 0,8'd0,  8'd0,  0,16'd0);
    vt[1]  = mk(0,0,0,8'd0,  1, 0,8'd0,  8'd0,  1,16'd0);
    vt[2]  = mk(0,0,0,8'd0,  1, 1,8'd0,  8'd4,  1,16'd1);
    vt[3]  = mk(0,0,0,8'd0,  1, 1,8'd4,  8'd8,  1,16'd2);
    vt[4]  = mk(0,0,0,8'd0,  1, 1,8'd8,  8'd12, 1,16'd3);
    vt[5]  = mk(0,0,0,8'd0,  1, 1,8'd12, 8'd16, 1,16'd4);
    vt[6]  = mk(0,0,0,8'd0,  0, 1,8'd16, 8'd20, 1,16'd5);
    vt[7]  = mk(0,0,0,8'd0,  0, 1,8'd16, 8'd24, 1,16'd6);
    vt[8]  = mk(0,0,0,8'd0,  0, 1,8'd16, 8'd24, 1,16'd6);
    vt[9]  = mk(0,0,1,8'd46, 0, 1,8'd16, 8'd24, 1,16'd6);
    vt[10] = mk(0,0,0,8'd0,  1, 0,8'd0,  8'd44, 1,16'd6);
    vt[11] = mk(0,0,0,8'd0,  1, 1,8'd44, 8'd48, 1,16'd7);
    vt[12] = mk(0,0,1,8'd252,1, 1,8'd48, 8'd52, 1,16'd8);
    vt[13] = mk(0,0,0,8'd0,  1, 0,8'd0,  8'd252,1,16'd8);
    vt[14] = mk(0,0,0,8'd0,  1, 1,8'd252,8'd0,  1,16'd9);
    vt[15] = mk(1,1,0,8'd0,  1, 1,8'd0,  8'd4,  1,16'd10);
    vt[16] = mk(0,0,0,8'd0,  1, 1,8'd4,  8'd8,  0,16'd11);
    vt[17] = mk(0,0,0,8'd0,  1, 0,8'd0,  8'd8,  0,16'd11);
    vt[18] = mk(1,0,0,8'd0,  1, 0,8'd0,  8'd8,  0,16'd11);
    vt[19] = mk(0,0,0,8'd0,  1, 0,8'd0,  8'd8,  1,16'd11);
    vt[20] = mk(0,0,0,8'd0,  1, 1,8'd8,  8'd12, 1,16'd12);
    vt[21] = mk(0,0,0,8'd0,  0, 1,8'd12, 8'd16, 1,16'd13);
    vt[22] = mk(0,0,0,8'd0,  0, 1,8'd12, 8'd20, 1,16'd14);

    for (int k = 0; k < 23; k++) begin
      if (k == 0)  begin push_exp(8'd0); push_exp(8'd4); push_exp(8'd8); push_exp(8'd12); end
      if (k == 9)  push_exp(8'd44);
      if (k == 12) begin push_exp(8'd252); push_exp(8'd0); push_exp(8'd4); end
      if (k == 18) push_exp(8'd8);
      cyc(vt[k].st, vt[k].hl, vt[k].rv, vt[k].ra, vt[k].rdy);
      chk($sformatf("v%0d_dec_valid", k), {31'd0, bus.dec_valid}, {31'd0, vt[k].dv});
      if (vt[k].dv) begin
        chk($sformatf("v%0d_dec_pc", k), {24'd0, bus.dec_pc}, {24'd0, vt[k].dpc});
        chk($sformatf("v%0d_dec_instr", k), bus.dec_instr, imem[vt[k].dpc[7:2]]);
      end
      chk($sformatf("v%0d_pc", k), {24'd0, pc}, {24'd0, vt[k].pcv});
      chk($sformatf("v%0d_im_addr", k), {24'd0, bus.im_addr}, {24'd0, vt[k].pcv});
      chk($sformatf("v%0d_busy", k), {31'd0, busy}, {31'd0, vt[k].bsy});
      chk($sformatf("v%0d_fetch_count", k), {16'd0, fetch_count}, {16'd0, vt[k].fc});
    end
    // Entry 12 was never accepted and stays queued until the reset below.
    chk("tbl_sb_pending", exp_q.size(), 32'd0);

    // ---------------- asynchronous reset with a full FIFO ----------------
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dec_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("arst_pc", {24'd0, pc}, 32'd0);
    chk("arst_fetch_count", {16'd0, fetch_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 8'd0, 1);
    cyc(0, 0, 0, 8'd0, 1);
    chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_idle_pc", {24'd0, pc}, 32'd0);
    chk("post_rst_idle_valid", {31'd0, bus.dec_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
